aabb_slab_resolve: RTL
======================

AABB_SLAB_RESOLVE -- requirements
Module: aabb_slab_resolve

Interface
REQ-001 SHALL have parameter WIDTH, default 25, MSB index of one float; float is WIDTH+1 bits = [WIDTH:WIDTH-1] exception, [WIDTH-2] sign, 11-bit exponent, 12-bit fraction (11_12 format).
REQ-002 SHALL have parameter ID_W, default 8, width of the ray tag.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  slab interval set present.
REQ-006 in_ready  output  1  block accepts the set this cycle.
REQ-007 in_id  input  ID_W  ray tag.
REQ-008 t0_x, t0_y, t0_z  input  WIDTH+1 each  per-axis slab entry distances.
REQ-009 t1_x, t1_y, t1_z  input  WIDTH+1 each  per-axis slab exit distances.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_id  output  ID_W  tag of the result.
REQ-013 out_hit  output  1  ray intersects box.
REQ-014 out_tnear  output  WIDTH+1  entry distance of the hit, zero encoding when miss.

Function
REQ-015 Transfer on each side SHALL occur only when valid and ready are both high on the same edge.
REQ-016 Stage 1 SHALL register tnear = max(t0_x,t0_y,t0_z) and tfar = min(t1_x,t1_y,t1_z), plus the id and a nan flag.
REQ-017 Stage 2 SHALL register hit = !nan && (tnear <= tfar) && (tfar >= +0), and out_tnear = tnear when hit, else 26'h0000000.
REQ-018 Latency SHALL be exactly 2 cycles from accept to out_valid with out_ready held high; throughput one set per cycle.
REQ-019 Ordering SHALL be total on exception classes: -inf < -normal < zero < +normal < +inf; +0 and -0 SHALL compare equal; normals SHALL order by {exponent,fraction}, reversed for negative sign.
REQ-020 Any input with exception 2'b11 (NaN) SHALL force out_hit = 0 for that set.
REQ-021 Ties in max/min SHALL select the lowest-indexed axis (x, then y, then z).
REQ-022 Each stage SHALL hold its contents while its successor is full and not advancing; no set SHALL be dropped or duplicated.
REQ-023 in_ready SHALL be high when stage 1 is empty or stage 1 advances in the same cycle (combinational from out_ready allowed).
REQ-024 Simultaneous accept and emit with both stages full SHALL shift the pipeline by one with no bubble.
REQ-025 Output payload SHALL remain stable while out_valid is high and out_ready is low.

Reset
REQ-026 While rst is low: both stage valid flags 0, out_valid 0, out_hit 0, out_tnear 0, out_id 0; in_ready SHALL read 1 once stage 1 is empty.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight sets; first accept after release yields out_valid exactly 2 cycles later.

Configuration
REQ-028 Macro AABB_HIT_COUNT_EN SHALL, when defined, add output hit_count (16 bits): increments on every emitted set with out_hit = 1, saturates at 16'hFFFF, reset to 0.
REQ-029 Without AABB_HIT_COUNT_EN the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-030 Exception codes (00 zero, 01 normal, 10 inf, 11 NaN), field offsets and the 26'h0000000 zero constant SHALL live in a shared package/include used by all ray-AABB blocks.
REQ-031 One combinational sub-module fp_le_cmp SHALL implement a<=b plus an unordered flag, instantiated for the max, min and final compare.

Verification
REQ-032 t0=(1.0,0.5,-1.0)=(26'h13FF000,26'h13FE000,26'h1BFF000), t1 all 2.0=26'h1400000, id 8'h05 -> 2 cycles later out_hit 1, out_tnear 26'h13FF000, out_id 8'h05.
REQ-033 t0_y = 3.0 (26'h1400800), t1 all 2.0 -> out_hit 0, out_tnear 26'h0000000.
REQ-034 t0 all -1.0, t1_z = -1.0, others 2.0 -> out_hit 0 (tfar behind origin).
REQ-035 t0_x = NaN (26'h3000000), remaining valid hit values -> out_hit 0.
REQ-036 Stream ids 1..6 back-to-back, out_ready low for cycles 3-5 -> in_ready drops when both stages full, outputs ids 1..6 in order, none lost, payload stable while stalled.
REQ-037 Reset pulsed low with two sets in flight -> out_valid 0 immediately; next set emerges after exactly 2 cycles; hit_count 0 after reset when AABB_HIT_COUNT_EN defined.

Source files
------------

// File: rtl/aabb_slab_resolve_pkg.sv
// Shared float encoding for the ray-AABB blocks: 11_12 float with a 2-bit exception class on top.
// Holds exception codes, field widths/offsets, the zero constant and the total-order rank helper.
package aabb_slab_resolve_pkg;

  typedef enum logic [1:0] {
    ExcZero   = 2'b00,
    ExcNormal = 2'b01,
    ExcInf    = 2'b10,
    ExcNan    = 2'b11
  } exc_e;

  localparam int unsigned ExpW  = 11;
  localparam int unsigned FracW = 12;
  localparam int unsigned MagW  = ExpW + FracW;

  // Offsets below the float MSB: exception occupies [msb:msb-1], sign sits at msb-2.
  localparam int unsigned ExcOff  = 0;
  localparam int unsigned SignOff = 2;

  localparam logic [25:0] FpZero = 26'h0000000;

  // Rank of the exception class in the total order -inf < -normal < zero < +normal < +inf.
  localparam logic [2:0] RankNegInf  = 3'd0;
  localparam logic [2:0] RankNegNorm = 3'd1;
  localparam logic [2:0] RankZero    = 3'd2;
  localparam logic [2:0] RankPosNorm = 3'd3;
  localparam logic [2:0] RankPosInf  = 3'd4;

  function automatic logic [2:0] fp_rank(input exc_e exc, input logic sign);
    logic [2:0] rank;
    rank = RankZero;
    unique case (exc)
      ExcZero:   rank = RankZero;
      ExcNormal: rank = sign ? RankNegNorm : RankPosNorm;
      ExcInf:    rank = sign ? RankNegInf : RankPosInf;
      ExcNan:    rank = RankZero;
      default:   rank = RankZero;
    endcase
    return rank;
  endfunction

endpackage

// File: rtl/fp_le_cmp.sv
// Combinational a <= b on the exception-tagged float, plus an unordered flag when either is NaN.
// Both zero signs rank equal; normals of equal sign order by magnitude, reversed when negative.
module fp_le_cmp
  import aabb_slab_resolve_pkg::*;
#(
  parameter int unsigned WIDTH = 25
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic           le,
  output logic           unordered
);

  exc_e             exc_a, exc_b;
  logic [2:0]       rank_a, rank_b;
  logic [WIDTH-3:0] mag_a, mag_b;

  assign exc_a  = exc_e'(a[WIDTH-ExcOff -: 2]);
  assign exc_b  = exc_e'(b[WIDTH-ExcOff -: 2]);
  assign rank_a = fp_rank(exc_a, a[WIDTH-SignOff]);
  assign rank_b = fp_rank(exc_b, b[WIDTH-SignOff]);
  assign mag_a  = a[WIDTH-3:0];
  assign mag_b  = b[WIDTH-3:0];

  assign unordered = (exc_a == ExcNan) || (exc_b == ExcNan);

  always_comb begin
    le = 1'b1;
    if (rank_a != rank_b) begin
      le = rank_a < rank_b;
    end else if (rank_a == RankNegNorm) begin
      le = mag_a >= mag_b;
    end else if (rank_a == RankPosNorm) begin
      le = mag_a <= mag_b;
    end
  end

endmodule

// File: rtl/aabb_slab_resolve.sv
// Two-stage ray/box slab resolve: stage 1 reduces per-axis entry/exit to tnear/tfar, stage 2 decides hit.
// Optional hit counter output enabled by defining AABB_HIT_COUNT_EN.
module aabb_slab_resolve
  import aabb_slab_resolve_pkg::*;
#(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned ID_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ID_W-1:0] in_id,
  input  logic [WIDTH:0]  t0_x,
  input  logic [WIDTH:0]  t0_y,
  input  logic [WIDTH:0]  t0_z,
  input  logic [WIDTH:0]  t1_x,
  input  logic [WIDTH:0]  t1_y,
  input  logic [WIDTH:0]  t1_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] out_id,
  output logic            out_hit,
  output logic [WIDTH:0]  out_tnear
`ifdef AABB_HIT_COUNT_EN
  ,
  output logic [15:0]     hit_count
`endif
);

  localparam logic [WIDTH:0] Zero = (WIDTH+1)'(FpZero);

  logic            s1_valid_q;
  logic [WIDTH:0]  s1_tnear_q, s1_tfar_q;
  logic [ID_W-1:0] s1_id_q;
  logic            s1_nan_q;

  logic            s2_valid_q;
  logic            s2_hit_q;
  logic [WIDTH:0]  s2_tnear_q;
  logic [ID_W-1:0] s2_id_q;

  logic s2_ready, s1_adv, accept;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign accept   = in_valid && in_ready;

  // Max of entries: keep the earlier axis unless the later one is strictly greater.
  logic           le_yx, le_zm, uo_yx, uo_zm;
  logic [WIDTH:0] max_xy, tnear_d;

  fp_le_cmp #(.WIDTH(WIDTH)) u_max_xy (.a(t0_y), .b(t0_x), .le(le_yx), .unordered(uo_yx));
  assign max_xy = le_yx ? t0_x : t0_y;
  fp_le_cmp #(.WIDTH(WIDTH)) u_max_z (.a(t0_z), .b(max_xy), .le(le_zm), .unordered(uo_zm));
  assign tnear_d = le_zm ? max_xy : t0_z;

  // Min of exits: keep the earlier axis unless the later one is strictly smaller.
  logic           le_xy, le_mz, uo_xy, uo_mz;
  logic [WIDTH:0] min_xy, tfar_d;

  fp_le_cmp #(.WIDTH(WIDTH)) u_min_xy (.a(t1_x), .b(t1_y), .le(le_xy), .unordered(uo_xy));
  assign min_xy = le_xy ? t1_x : t1_y;
  fp_le_cmp #(.WIDTH(WIDTH)) u_min_z (.a(min_xy), .b(t1_z), .le(le_mz), .unordered(uo_mz));
  assign tfar_d = le_mz ? min_xy : t1_z;

  logic nan_d;
  assign nan_d = uo_yx || uo_zm || uo_xy || uo_mz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_tnear_q <= Zero;
      s1_tfar_q  <= Zero;
      s1_id_q    <= '0;
      s1_nan_q   <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_tnear_q <= tnear_d;
      s1_tfar_q  <= tfar_d;
      s1_id_q    <= in_id;
      s1_nan_q   <= nan_d;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  logic le_nf, uo_nf, le_zf, uo_zf, hit_d;

  fp_le_cmp #(.WIDTH(WIDTH)) u_near_far (
    .a(s1_tnear_q), .b(s1_tfar_q), .le(le_nf), .unordered(uo_nf)
  );
  fp_le_cmp #(.WIDTH(WIDTH)) u_zero_far (
    .a(Zero), .b(s1_tfar_q), .le(le_zf), .unordered(uo_zf)
  );

  assign hit_d = !s1_nan_q && !uo_nf && !uo_zf && le_nf && le_zf;

  // Stage 2 only loads when the consumer can take it, so the payload is frozen under stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_tnear_q <= Zero;
      s2_id_q    <= '0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_hit_q   <= hit_d;
        s2_tnear_q <= hit_d ? s1_tnear_q : Zero;
        s2_id_q    <= s1_id_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_hit   = s2_hit_q;
  assign out_tnear = s2_tnear_q;
  assign out_id    = s2_id_q;

`ifdef AABB_HIT_COUNT_EN
  logic [15:0] hit_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q <= 16'h0000;
    end else if (s2_valid_q && out_ready && s2_hit_q && (hit_count_q != 16'hFFFF)) begin
      hit_count_q <= hit_count_q + 16'h0001;
    end
  end

  assign hit_count = hit_count_q;
`else
  // No hit counter in this build.
`endif

endmodule
